// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared constants for the execute-stage forwarding and hazard unit.
// Forward select codes match the operand mux port order.
package forwarding_hazard_unit_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/forwarding_hazard_unit_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Operand forwarding selects, load-use stall and branch flush controls for the
// RV32I core, driven from a private shadow of the E/M/W destination state.
module forwarding_hazard_unit #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] RdD,
    input  logic                  RegWriteD,
    input  logic                  LoadD,
    input  logic                  PCSrcE,
    input  logic                  cnt_clr,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    import forwarding_hazard_unit_pkg::X0;
    import forwarding_hazard_unit_pkg::FWD_RF;
    import forwarding_hazard_unit_pkg::FWD_WB;
    import forwarding_hazard_unit_pkg::FWD_MEM;

    localparam logic [REG_ADDR_W-1:0] Zero = REG_ADDR_W'(X0);

    logic [REG_ADDR_W-1:0] rs1_e_q, rs2_e_q, rd_e_q, rd_m_q, rd_w_q;
    logic                  we_e_q, load_e_q, we_m_q, we_w_q;
    logic                  lw_stall, flush_e;

    // Memory stage outranks writeback: it holds the younger value.
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                           input logic [REG_ADDR_W-1:0] rd_m,
                                           input logic                  we_m,
                                           input logic [REG_ADDR_W-1:0] rd_w,
                                           input logic                  we_w);
        if (rs == Zero) begin
            return FWD_RF;
        end else if (we_m && (rd_m == rs)) begin
            return FWD_MEM;
        end else if (we_w && (rd_w == rs)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    assign lw_stall = load_e_q && (rd_e_q != Zero) && ((rd_e_q == Rs1D) || (rd_e_q == Rs2D));
    assign flush_e  = lw_stall || PCSrcE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rs1_e_q  <= '0;
            rs2_e_q  <= '0;
            rd_e_q   <= '0;
            we_e_q   <= 1'b0;
            load_e_q <= 1'b0;
            rd_m_q   <= '0;
            we_m_q   <= 1'b0;
            rd_w_q   <= '0;
            we_w_q   <= 1'b0;
        end else begin
            if (flush_e) begin
                rs1_e_q  <= '0;
                rs2_e_q  <= '0;
                rd_e_q   <= '0;
                we_e_q   <= 1'b0;
                load_e_q <= 1'b0;
            end else begin
                rs1_e_q  <= Rs1D;
                rs2_e_q  <= Rs2D;
                rd_e_q   <= RdD;
                we_e_q   <= RegWriteD;
                load_e_q <= LoadD;
            end
            // M and W always advance; a stall only holds fetch/decode.
            rd_m_q <= rd_e_q;
            we_m_q <= we_e_q;
            rd_w_q <= rd_m_q;
            we_w_q <= we_m_q;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk_i (clk),
        .rst_ni(reset_n),
        .inc_i (lw_stall),
        .clr_i (cnt_clr),
        .cnt_o (stall_cnt)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_flush_cnt (
        .clk_i (clk),
        .rst_ni(reset_n),
        .inc_i (PCSrcE),
        .clr_i (cnt_clr),
        .cnt_o (flush_cnt)
    );

    assign ForwardAE = fwd_sel(rs1_e_q, rd_m_q, we_m_q, rd_w_q, we_w_q);
    assign ForwardBE = fwd_sel(rs2_e_q, rd_m_q, we_m_q, rd_w_q, we_w_q);
    assign StallF    = lw_stall;
    assign StallD    = lw_stall;
    // PCSrcE is a raw input, so gate it to keep outputs quiet during reset.
    assign FlushD    = PCSrcE && reset_n;
    assign FlushE    = flush_e && reset_n;

endmodule
